// File: rtl/decode_branch_resolver.sv
// Decode-stage branch resolver: statically resolves JAL/B-type words at accept,
// queues correct-path words in a FWFT FIFO and drops wrong-path words after a taken redirect.
module decode_branch_resolver #(
  parameter int DEPTH      = 4,
  parameter int DROP_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dec_instr,
  input  logic [31:0] dec_pc,
  input  logic        dec_valid,
  output logic        dec_read_en,
  output logic        branch_resolved,
  output logic        branch_taken,
  output logic [31:0] branch_pc,
  output logic [31:0] branch_target,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_redirect
);

  localparam int DATA_W = 32;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = AW + 1;
  localparam int DW     = $clog2(DROP_LIMIT + 1);

  typedef enum logic {RUN = 1'b0, REDIRECT = 1'b1} state_t;

  function automatic logic signed [DATA_W-1:0] j_imm(input logic [31:0] ins);
    return {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic signed [DATA_W-1:0] b_imm(input logic [31:0] ins);
    return {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  state_t                    state, state_nxt;
  logic [CW-1:0]             count;
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [DATA_W-1:0]         q_instr [DEPTH];
  logic [DATA_W-1:0]         q_pc    [DEPTH];
  logic [DW-1:0]             drop_cnt;
  logic [DATA_W-1:0]         exp_pc;
  logic                      err_q;

  logic                      vld_p1, taken_p1;
  logic [DATA_W-1:0]         pc_p1, tgt_p1;

  logic                      is_jal, is_bcc, is_branch, br_taken;
  logic signed [DATA_W-1:0]  pc_s, offset;
  logic [DATA_W-1:0]         next_tgt;
  logic                      accept, pc_match, drop_last;
  logic                      take_word, drop, resolve, enter_redir;
  logic                      push, pop;

  // Decode at accept (stage p0)
  always_comb begin
    is_jal    = (dec_instr[6:0] == 7'b1101111);
    is_bcc    = (dec_instr[6:0] == 7'b1100011);
    is_branch = is_jal | is_bcc;
    br_taken  = is_jal | (is_bcc & dec_instr[31]);
    pc_s      = dec_pc;
    offset    = is_jal ? j_imm(dec_instr) : b_imm(dec_instr);
    next_tgt  = br_taken ? DATA_W'(pc_s + offset) : dec_pc + 32'd4;
  end

  assign dec_read_en = rst_n & (count < CW'(DEPTH));
  assign accept      = dec_valid & dec_read_en;
  assign pc_match    = (dec_pc == exp_pc);
  assign drop_last   = (drop_cnt == DW'(DROP_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:      if (enter_redir) state_nxt = REDIRECT;
      REDIRECT: begin
        if (enter_redir)            state_nxt = REDIRECT;
        else if (take_word)         state_nxt = RUN;
        else if (drop && drop_last) state_nxt = RUN;
      end
      default:  state_nxt = RUN;
    endcase
  end

  always_comb begin
    take_word   = accept & ((state == RUN) | pc_match);
    drop        = accept & (state == REDIRECT) & ~pc_match;
    resolve     = take_word & is_branch;
    enter_redir = take_word & br_taken;
  end

  // Resolution register and redirect bookkeeping (stage p1)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      taken_p1 <= 1'b0;
      pc_p1    <= '0;
      tgt_p1   <= '0;
      drop_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      vld_p1 <= resolve;
      if (resolve) begin
        taken_p1 <= br_taken;
        pc_p1    <= dec_pc;
        tgt_p1   <= next_tgt;
      end
      if (enter_redir)  drop_cnt <= '0;
      else if (drop)    drop_cnt <= drop_cnt + DW'(1);
      if (drop && drop_last) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enter_redir) exp_pc <= next_tgt;
  end

  assign branch_resolved = vld_p1;
  assign branch_taken    = taken_p1;
  assign branch_pc       = pc_p1;
  assign branch_target   = tgt_p1;
  assign err_redirect    = err_q;

  // Instruction queue, first-word-fall-through
  assign push      = take_word;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign out_instr = q_instr[rd_ptr];
  assign out_pc    = q_pc[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr] <= dec_instr;
      q_pc[wr_ptr]    <= dec_pc;
    end
  end

endmodule

// File: tb/tb_decode_branch_resolver.sv
// Directed self-checking bench for decode_branch_resolver.
module tb_decode_branch_resolver;

  logic        clk;
  logic        rst_n;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_valid;
  logic        dec_read_en;
  logic        branch_resolved;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] branch_target;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_valid;
  logic        out_ready;
  logic        err_redirect;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] JAL = 32'h0100_006F;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_res = 0;
  int          res_base = 0;
  int          got_base = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  decode_branch_resolver #(.DEPTH(4), .DROP_LIMIT(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc),
    .dec_valid       (dec_valid),
    .dec_read_en     (dec_read_en),
    .branch_resolved (branch_resolved),
    .branch_taken    (branch_taken),
    .branch_pc       (branch_pc),
    .branch_target   (branch_target),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .err_redirect    (err_redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back(out_pc);
    if (branch_resolved) n_res++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    dec_instr = ins;
    dec_pc    = pc;
    dec_valid = 1'b1;
    tick();
  endtask

  task automatic check_order(input string tag);
    chk({tag, "_cnt"}, 32'(got_q.size() - got_base), 32'(exp_q.size()));
    foreach (exp_q[i])
      chk(tag, (got_base + i < got_q.size()) ? got_q[got_base + i] : 32'hFFFF_FFFF, exp_q[i]);
    got_base = got_q.size();
    exp_q.delete();
  endtask

  task automatic check_res(input string tag, input int exp);
    chk(tag, 32'(n_res - res_base), 32'(exp));
    res_base = n_res;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; dec_valid = 1'b0; dec_instr = '0; dec_pc = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_read_en", dec_read_en, 0);
    chk("rst_resolved", branch_resolved, 0);
    chk("rst_taken", branch_taken, 0);
    chk("rst_bpc", branch_pc, 0);
    chk("rst_btgt", branch_target, 0);
    chk("rst_err", err_redirect, 0);
    chk("rst_fsm", 32'(dut.state), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_read_en_up", dec_read_en, 1);

    // plain words stream through in order
    out_ready = 1'b1;
    send(NOP, 32'h0); send(NOP, 32'h4); send(NOP, 32'h8);
    dec_valid = 1'b0;
    repeat (6) tick();
    exp_q = {32'h0, 32'h4, 32'h8};
    check_order("nop_order");
    check_res("nop_no_resolve", 0);

    // backpressure: four fill the queue, the fifth waits for a pop
    out_ready = 1'b0;
    send(NOP, 32'h10); send(NOP, 32'h14); send(NOP, 32'h18); send(NOP, 32'h1C);
    chk("full_read_en", dec_read_en, 0);
    dec_pc = 32'h20;
    tick();
    chk("full_head", out_pc, 32'h10);
    chk("full_read_en2", dec_read_en, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("after_pop_read_en", dec_read_en, 1);
    tick();
    dec_valid = 1'b0;
    chk("refill_read_en", dec_read_en, 0);
    out_ready = 1'b1;
    repeat (6) tick();
    exp_q = {32'h10, 32'h14, 32'h18, 32'h1C, 32'h20};
    check_order("bp_order");

    // JAL redirect, wrong-path words dropped
    send(JAL, 32'h100);
    chk("jal_resolved", branch_resolved, 1);
    chk("jal_taken", branch_taken, 1);
    chk("jal_pc", branch_pc, 32'h100);
    chk("jal_target", branch_target, 32'h110);
    send(NOP, 32'h104);
    chk("jal_pulse_once", branch_resolved, 0);
    chk("jal_target_hold", branch_target, 32'h110);
    chk("jal_fsm_redirect", 32'(dut.state), 1);
    send(NOP, 32'h108); send(NOP, 32'h10C); send(NOP, 32'h110);
    dec_valid = 1'b0;
    chk("jal_fsm_run", 32'(dut.state), 0);
    chk("jal_err", err_redirect, 0);
    repeat (5) tick();
    exp_q = {32'h100, 32'h110};
    check_order("jal_order");
    check_res("jal_resolve_cnt", 1);

    // B-type static resolution: backward taken, forward not taken
    send(32'hFE00_0EE3, 32'h200);
    chk("bbk_resolved", branch_resolved, 1);
    chk("bbk_taken", branch_taken, 1);
    chk("bbk_pc", branch_pc, 32'h200);
    chk("bbk_target", branch_target, 32'h1FC);
    send(NOP, 32'h1FC);
    send(32'h0000_0463, 32'h300);
    chk("bfw_resolved", branch_resolved, 1);
    chk("bfw_taken", branch_taken, 0);
    chk("bfw_pc", branch_pc, 32'h300);
    chk("bfw_target", branch_target, 32'h304);
    dec_valid = 1'b0;
    tick();
    chk("bfw_fsm_run", 32'(dut.state), 0);
    repeat (5) tick();
    exp_q = {32'h200, 32'h1FC, 32'h300};
    check_order("bcc_order");
    check_res("bcc_resolve_cnt", 2);

    // redirect abandoned after DROP_LIMIT mismatches
    send(JAL, 32'h400);
    for (int k = 0; k < 7; k++) send(NOP, 32'h500 + 32'(4 * k));
    chk("to_fsm_still_redirect", 32'(dut.state), 1);
    chk("to_err_not_yet", err_redirect, 0);
    send(NOP, 32'h51C);
    chk("to_fsm_run", 32'(dut.state), 0);
    chk("to_err_set", err_redirect, 1);
    send(NOP, 32'h600);
    dec_valid = 1'b0;
    repeat (5) tick();
    chk("to_err_sticky", err_redirect, 1);
    exp_q = {32'h400, 32'h600};
    check_order("to_order");
    check_res("to_resolve_cnt", 1);

    // reset in the middle of a redirect with a populated queue
    out_ready = 1'b0;
    send(NOP, 32'h700); send(NOP, 32'h704); send(JAL, 32'h708);
    dec_valid = 1'b0;
    chk("mid_fsm_redirect", 32'(dut.state), 1);
    chk("mid_out_valid", out_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_err", err_redirect, 0);
    chk("mid_rst_fsm", 32'(dut.state), 0);
    chk("mid_rst_read_en", dec_read_en, 0);
    chk("mid_rst_resolved", branch_resolved, 0);
    chk("mid_rst_bpc", branch_pc, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mid_read_en_up", dec_read_en, 1);
    out_ready = 1'b1;
    send(NOP, 32'h804);
    dec_valid = 1'b0;
    chk("post_rst_head", out_pc, 32'h804);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
